sramlike_arbiter: RTL and testbench

SRAMLIKE_ARBITER -- requirements
Module: sramlike_arbiter

---
 rtl/sramlike_pkg.sv | 21 ++
 rtl/sramlike_id_fifo.sv | 66 ++++++
 rtl/sramlike_arbiter.sv | 155 +++++++++++++++
 tb/tb_sramlike_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sramlike_pkg.sv
// Shared types for the sram-like arbiter: transfer sizes, FSM states and
// the channel-ID width helper.
package sramlike_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

  // A single channel still needs one bit so ID vectors never collapse to zero width.
  function automatic int id_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/sramlike_id_fifo.sv
// In-order FIFO of accepted channel IDs; the head names the channel that
// owns the next slave data response.
module sramlike_id_fifo
  import sramlike_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ID_W-1:0]            din,
  output logic [ID_W-1:0]            head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/sramlike_arbiter.sv
// Round-robin arbiter merging NUM_CH sram-like masters onto one slave port,
// with an ID FIFO routing data responses back in acceptance order.
module sramlike_arbiter
  import sramlike_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        m_req,
  input  logic [NUM_CH-1:0]        m_wr,
  input  logic [2*NUM_CH-1:0]      m_size,
  input  logic [ADDR_W*NUM_CH-1:0] m_addr,
  input  logic [DATA_W*NUM_CH-1:0] m_wdata,
  output logic [NUM_CH-1:0]        m_addr_ok,
  output logic [NUM_CH-1:0]        m_data_ok,
  output logic [DATA_W-1:0]        m_rdata,
  output logic                     s_req,
  output logic                     s_wr,
  output logic [1:0]               s_size,
  output logic [ADDR_W-1:0]        s_addr,
  output logic [DATA_W-1:0]        s_wdata,
  input  logic                     s_addr_ok,
  input  logic                     s_data_ok,
  input  logic [DATA_W-1:0]        s_rdata,
  output logic                     err
);

  localparam int ID_W  = id_width(NUM_CH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  arb_state_e       state_q;
  logic [ID_W-1:0]  grant_q;
  logic [ID_W-1:0]  ptr_q;
  logic             err_q;

  logic [ADDR_W-1:0] addr_a  [NUM_CH];
  logic [DATA_W-1:0] wdata_a [NUM_CH];
  logic [1:0]        size_a  [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign addr_a[g]  = m_addr[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = m_wdata[g*DATA_W +: DATA_W];
    assign size_a[g]  = m_size[2*g +: 2];
  end

  function automatic logic [ID_W-1:0] wrap_id(input int v);
    int r;
    r = (v >= NUM_CH) ? v - NUM_CH : v;
    return ID_W'(r);
  endfunction

  logic [2*NUM_CH-1:0] req_rot;
  logic                found;
  logic [ID_W-1:0]     pick;

  // Rotate the request vector so bit 0 is the channel at the priority pointer.
  assign req_rot = {m_req, m_req} >> ptr_q;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && req_rot[i]) begin
        found = 1'b1;
        pick  = wrap_id(int'(ptr_q) + i);
      end
    end
  end

  logic             hold, gnt_live, accept, viol;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic             bypass, data_err;
  logic [ID_W-1:0]  fifo_head;
  logic [CNT_W-1:0] fifo_count;

  assign hold     = (state_q == ST_HOLD);
  assign gnt_live = hold && m_req[grant_q];
  assign viol     = hold && !m_req[grant_q];
  assign accept   = gnt_live && s_addr_ok;

  // An empty FIFO with a same-cycle accept means the slave answered this very
  // request, so the response goes straight to the grant instead of the FIFO.
  assign fifo_pop  = s_data_ok && !fifo_empty;
  assign bypass    = s_data_ok && fifo_empty && accept;
  assign data_err  = s_data_ok && fifo_empty && !accept;
  assign fifo_push = accept && !bypass;

  sramlike_id_fifo #(
    .DEPTH (DEPTH),
    .ID_W  (ID_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (grant_q),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign s_req   = gnt_live;
  assign s_wr    = m_wr[grant_q];
  assign s_size  = size_a[grant_q];
  assign s_addr  = addr_a[grant_q];
  assign s_wdata = wdata_a[grant_q];
  assign m_rdata = s_rdata;
  assign err     = err_q;

  always_comb begin
    m_addr_ok = '0;
    m_data_ok = '0;
    if (accept) m_addr_ok = NUM_CH'(1) << grant_q;
    if (fifo_pop)    m_data_ok = NUM_CH'(1) << fifo_head;
    else if (bypass) m_data_ok = NUM_CH'(1) << grant_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_ARB;
      grant_q <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (data_err) err_q <= 1'b1;
      case (state_q)
        ST_ARB: begin
          if (found && !fifo_full) begin
            grant_q <= pick;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (viol) begin
            err_q   <= 1'b1;
            state_q <= ST_ARB;
          end else if (s_addr_ok) begin
            ptr_q   <= wrap_id(int'(grant_q) + 1);
            state_q <= ST_ARB;
          end
        end
        default: state_q <= ST_ARB;
      endcase
    end
  end

  logic unused_count;
  assign unused_count = ^fifo_count;

endmodule

// File: tb/tb_sramlike_arbiter.sv
// Directed bench for sramlike_arbiter (2 channels, DEPTH 4).
module tb_sramlike_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_req, m_wr;
  logic [3:0]  m_size;
  logic [63:0] m_addr, m_wdata;
  logic [1:0]  m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;
  logic        s_req, s_wr;
  logic [1:0]  s_size;
  logic [31:0] s_addr, s_wdata;
  logic        s_addr_ok, s_data_ok;
  logic [31:0] s_rdata;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  int mon_ao0 = 0, mon_do0 = 0, mon_ch1 = 0;

  sramlike_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_addr_ok[0]) mon_ao0 <= mon_ao0 + 1;
    if (m_data_ok[0]) mon_do0 <= mon_do0 + 1;
    if (m_addr_ok[1] || m_data_ok[1]) mon_ch1 <= mon_ch1 + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_sreq(input string tag);
    int n = 0;
    while (!s_req && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 64'(s_req), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m_req = '0;
    s_addr_ok = 1'b0;
    s_data_ok = 1'b0;
    s_rdata = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Accept one request from channel ch and check the fields presented to the slave.
  task automatic issue(input int ch);
    logic [1:0] oh;
    oh = 2'b01 << ch;
    m_req[ch] = 1'b1;
    wait_sreq("iss_sreq");
    chk("iss_addr", 64'(s_addr), (ch == 0) ? 64'h1000 : 64'h2000);
    chk("iss_wr",   64'(s_wr),   (ch == 0) ? 64'd0 : 64'd1);
    if (ch == 1) begin
      chk("iss_size",  64'(s_size),  64'd1);
      chk("iss_wdata", 64'(s_wdata), 64'hCAFE_F00D);
    end
    s_addr_ok = 1'b1;
    #1;
    chk("iss_addr_ok", 64'(m_addr_ok), 64'(oh));
    tick();
    s_addr_ok = 1'b0;
    m_req[ch] = 1'b0;
  endtask

  initial begin
    int a0, d0, c1, n_acc;
    m_wr   = 2'b10;
    m_size = {2'd1, 2'd2};
    m_addr = {32'h0000_2000, 32'h0000_1000};
    m_wdata = {32'hCAFE_F00D, 32'h1111_1111};
    rst = 1'b0;
    m_req = '0;
    s_addr_ok = 1'b0;
    s_data_ok = 1'b0;
    s_rdata = '0;
    #3;
    chk("rst_sreq",  64'(s_req), 64'd0);
    chk("rst_aok",   64'(m_addr_ok), 64'd0);
    chk("rst_dok",   64'(m_data_ok), 64'd0);
    chk("rst_err",   64'(err), 64'd0);
    chk("rst_count", 64'(dut.u_fifo.count), 64'd0);
    do_reset();

    // single read
    a0 = mon_ao0; d0 = mon_do0; c1 = mon_ch1;
    m_req = 2'b01;
    wait_sreq("rd_sreq");
    chk("rd_addr", 64'(s_addr), 64'h1000);
    tick();
    chk("rd_sreq_hold", 64'(s_req), 64'd1);
    chk("rd_addr_hold", 64'(s_addr), 64'h1000);
    s_addr_ok = 1'b1;
    #1;
    chk("rd_aok", 64'(m_addr_ok), 64'h1);
    tick();
    s_addr_ok = 1'b0;
    m_req = 2'b00;
    #1;
    chk("rd_aok_drop", 64'(m_addr_ok), 64'h0);
    tick();
    tick();
    s_data_ok = 1'b1;
    s_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rd_dok", 64'(m_data_ok), 64'h1);
    chk("rd_rdata", 64'(m_rdata), 64'hDEAD_BEEF);
    tick();
    s_data_ok = 1'b0;
    tick();
    chk("rd_aok_pulses", 64'(mon_ao0 - a0), 64'd1);
    chk("rd_dok_pulses", 64'(mon_do0 - d0), 64'd1);
    chk("rd_ch1_pulses", 64'(mon_ch1 - c1), 64'd0);
    chk("rd_err", 64'(err), 64'd0);

    // fairness, each accept answered by same-cycle bypass data
    do_reset();
    m_req = 2'b11;
    s_addr_ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_sreq("fair_sreq");
      s_data_ok = 1'b1;
      #1;
      chk("fair_grant", 64'(m_addr_ok), (k % 2 == 0) ? 64'h1 : 64'h2);
      chk("fair_bypass", 64'(m_data_ok), (k % 2 == 0) ? 64'h1 : 64'h2);
      tick();
      s_data_ok = 1'b0;
    end
    m_req = 2'b00;
    s_addr_ok = 1'b0;
    tick();
    chk("fair_count", 64'(dut.u_fifo.count), 64'd0);
    chk("fair_err", 64'(err), 64'd0);

    // backpressure
    do_reset();
    m_req = 2'b01;
    s_addr_ok = 1'b1;
    n_acc = 0;
    for (int k = 0; k < 20; k++) begin
      if (s_req) n_acc++;
      tick();
    end
    chk("bp_accepts", 64'(n_acc), 64'd4);
    chk("bp_count", 64'(dut.u_fifo.count), 64'd4);
    chk("bp_sreq_low", 64'(s_req), 64'd0);
    s_data_ok = 1'b1;
    s_rdata = 32'h0000_0001;
    #1;
    chk("bp_dok", 64'(m_data_ok), 64'h1);
    tick();
    s_data_ok = 1'b0;
    wait_sreq("bp_5th_sreq");
    tick();
    chk("bp_count_refill", 64'(dut.u_fifo.count), 64'd4);
    m_req = 2'b00;
    s_addr_ok = 1'b0;

    // ordering
    do_reset();
    issue(1);
    issue(0);
    issue(1);
    chk("ord_count", 64'(dut.u_fifo.count), 64'd3);
    for (int k = 0; k < 3; k++) begin
      s_data_ok = 1'b1;
      s_rdata = 32'hA000_0000 + 32'(k);
      #1;
      chk("ord_dok", 64'(m_data_ok), (k == 1) ? 64'h1 : 64'h2);
      chk("ord_rdata", 64'(m_rdata), 64'hA000_0000 + 64'(k));
      tick();
      s_data_ok = 1'b0;
    end
    chk("ord_count_end", 64'(dut.u_fifo.count), 64'd0);
    chk("ord_err", 64'(err), 64'd0);

    // bypass then stray data_ok
    do_reset();
    m_req = 2'b10;
    wait_sreq("byp_sreq");
    s_addr_ok = 1'b1;
    s_data_ok = 1'b1;
    #1;
    chk("byp_dok", 64'(m_data_ok), 64'h2);
    tick();
    s_addr_ok = 1'b0;
    s_data_ok = 1'b0;
    m_req = 2'b00;
    #1;
    chk("byp_err", 64'(err), 64'd0);
    chk("byp_count", 64'(dut.u_fifo.count), 64'd0);
    tick();
    s_data_ok = 1'b1;
    #1;
    chk("stray_dok", 64'(m_data_ok), 64'h0);
    tick();
    s_data_ok = 1'b0;
    chk("stray_err", 64'(err), 64'd1);

    // master drops request while held
    do_reset();
    m_req = 2'b01;
    wait_sreq("viol_sreq");
    m_req = 2'b00;
    #1;
    chk("viol_sreq_drop", 64'(s_req), 64'd0);
    tick();
    chk("viol_err", 64'(err), 64'd1);
    chk("viol_count", 64'(dut.u_fifo.count), 64'd0);
    tick();
    chk("viol_sreq_idle", 64'(s_req), 64'd0);

    // reset with two outstanding
    do_reset();
    issue(0);
    issue(1);
    chk("mid_count", 64'(dut.u_fifo.count), 64'd2);
    m_req = 2'b01;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_sreq", 64'(s_req), 64'd0);
    chk("mid_aok", 64'(m_addr_ok), 64'd0);
    chk("mid_dok", 64'(m_data_ok), 64'd0);
    chk("mid_err", 64'(err), 64'd0);
    chk("mid_count_rst", 64'(dut.u_fifo.count), 64'd0);
    m_req = 2'b00;
    tick();
    rst = 1'b1;
    s_data_ok = 1'b1;
    #1;
    chk("late_dok", 64'(m_data_ok), 64'd0);
    tick();
    s_data_ok = 1'b0;
    chk("late_err", 64'(err), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
